// File: rtl/tlb_walk_mem_arbiter.sv
// tlb_walk_mem_arbiter
//   Shares one memory port between the ITLB and DTLB page-table walkers.
//   Round-robin arbitration; the granted walker may hold the port across
//   several accesses of one walk by keeping its lock input high.
//
//   Optional build macro: TLB_WALK_ARB_PERF_EN enables the perf counters.
//   When it is undefined the perf outputs are tied to zero.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_mem*, i_lock            ITLB walker request side
//   d_mem*, d_lock            DTLB walker request side
//   mem*                      shared memory port towards cache/bus
//   grantId                   0 = ITLB owns port, 1 = DTLB (valid when busy)
//   busy                      port is owned (access in flight or held)
//   perfIAccess/perfDAccess   completed accesses per walker
//   perfConflict              cycles a non-granted walker waited
module tlb_walk_mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 34,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_memAddr,
    input  logic                  i_memReadEnable,
    input  logic                  i_memWriteEnable,
    input  logic [DATA_WIDTH-1:0] i_memWriteValue,
    input  logic                  i_lock,
    output logic                  i_memReadDone,
    output logic                  i_memWriteDone,
    output logic [DATA_WIDTH-1:0] i_memReadValue,

    input  logic [ADDR_WIDTH-1:0] d_memAddr,
    input  logic                  d_memReadEnable,
    input  logic                  d_memWriteEnable,
    input  logic [DATA_WIDTH-1:0] d_memWriteValue,
    input  logic                  d_lock,
    output logic                  d_memReadDone,
    output logic                  d_memWriteDone,
    output logic [DATA_WIDTH-1:0] d_memReadValue,

    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic                  memReadEnable,
    output logic                  memWriteEnable,
    output logic [DATA_WIDTH-1:0] memWriteValue,
    input  logic                  memReadDone,
    input  logic                  memWriteDone,
    input  logic [DATA_WIDTH-1:0] memReadValue,

    output logic                  grantId,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  perfIAccess,
    output logic [CNT_WIDTH-1:0]  perfDAccess,
    output logic [CNT_WIDTH-1:0]  perfConflict
);

    typedef enum logic [1:0] {StIdle, StBusy, StHold} state_e;

    state_e                state;
    logic                  grant_id;
    logic                  last_grant;
    logic [ADDR_WIDTH-1:0] cap_addr;
    logic                  cap_rd;
    logic                  cap_wr;
    logic [DATA_WIDTH-1:0] cap_wdata;

    logic                  i_req;
    logic                  d_req;
    logic                  g_req;
    logic                  g_lock;
    logic                  idle_sel;
    logic                  cap_sel;
    logic                  sel_rd;
    logic                  sel_wr;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  done;

    assign i_req  = i_memReadEnable | i_memWriteEnable;
    assign d_req  = d_memReadEnable | d_memWriteEnable;
    assign g_req  = grant_id ? d_req  : i_req;
    assign g_lock = grant_id ? d_lock : i_lock;

    // On a tie the walker that was not served last wins; otherwise whoever asks.
    assign idle_sel = (i_req & d_req) ? ~last_grant : d_req;
    // In HOLD only the current owner can be captured.
    assign cap_sel  = (state == StHold) ? grant_id : idle_sel;

    assign sel_rd    = cap_sel ? d_memReadEnable  : i_memReadEnable;
    assign sel_wr    = cap_sel ? d_memWriteEnable : i_memWriteEnable;
    assign sel_addr  = cap_sel ? d_memAddr        : i_memAddr;
    assign sel_wdata = cap_sel ? d_memWriteValue  : i_memWriteValue;

    // Captured rd/wr are only non-zero while BUSY, so no state qualifier needed.
    assign done = (memReadDone & cap_rd) | (memWriteDone & cap_wr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= StIdle;
            grant_id   <= 1'b0;
            last_grant <= 1'b1;
            cap_addr   <= '0;
            cap_rd     <= 1'b0;
            cap_wr     <= 1'b0;
            cap_wdata  <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (i_req | d_req) begin
                        grant_id  <= idle_sel;
                        cap_addr  <= sel_addr;
                        cap_rd    <= sel_rd;
                        cap_wr    <= sel_wr & ~sel_rd;
                        cap_wdata <= sel_wdata;
                        state     <= StBusy;
                    end
                end
                StBusy: begin
                    // Runs to completion even if the requester has dropped its enable.
                    if (done) begin
                        last_grant <= grant_id;
                        cap_addr   <= '0;
                        cap_rd     <= 1'b0;
                        cap_wr     <= 1'b0;
                        cap_wdata  <= '0;
                        state      <= g_lock ? StHold : StIdle;
                    end
                end
                StHold: begin
                    if (g_req) begin
                        cap_addr  <= sel_addr;
                        cap_rd    <= sel_rd;
                        cap_wr    <= sel_wr & ~sel_rd;
                        cap_wdata <= sel_wdata;
                        state     <= StBusy;
                    end else if (!g_lock) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign memAddr        = cap_addr;
    assign memReadEnable  = cap_rd;
    assign memWriteEnable = cap_wr;
    assign memWriteValue  = cap_wdata;

    assign grantId = grant_id;
    assign busy    = (state != StIdle);

    assign i_memReadDone  = memReadDone  & cap_rd & ~grant_id;
    assign i_memWriteDone = memWriteDone & cap_wr & ~grant_id;
    assign d_memReadDone  = memReadDone  & cap_rd &  grant_id;
    assign d_memWriteDone = memWriteDone & cap_wr &  grant_id;
    assign i_memReadValue = memReadValue;
    assign d_memReadValue = memReadValue;

`ifdef TLB_WALK_ARB_PERF_EN
    logic                 conflict;
    logic [CNT_WIDTH-1:0] cnt_i;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic [CNT_WIDTH-1:0] cnt_c;

    assign conflict = (state != StIdle) & (grant_id ? i_req : d_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_i <= '0;
            cnt_d <= '0;
            cnt_c <= '0;
        end else begin
            if (done && !grant_id) cnt_i <= cnt_i + CNT_WIDTH'(1);
            if (done &&  grant_id) cnt_d <= cnt_d + CNT_WIDTH'(1);
            if (conflict)          cnt_c <= cnt_c + CNT_WIDTH'(1);
        end
    end

    assign perfIAccess  = cnt_i;
    assign perfDAccess  = cnt_d;
    assign perfConflict = cnt_c;
`else
    assign perfIAccess  = '0;
    assign perfDAccess  = '0;
    assign perfConflict = '0;
`endif

endmodule

// File: tb/tb_tlb_walk_mem_arbiter.sv
module tb_tlb_walk_mem_arbiter;
    localparam int AW = 34;
    localparam int DW = 32;
    localparam int CW = 32;
`ifdef TLB_WALK_ARB_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [AW-1:0] i_memAddr, d_memAddr, memAddr;
    logic i_memReadEnable, i_memWriteEnable, i_lock, i_memReadDone, i_memWriteDone;
    logic d_memReadEnable, d_memWriteEnable, d_lock, d_memReadDone, d_memWriteDone;
    logic [DW-1:0] i_memWriteValue, i_memReadValue, d_memWriteValue, d_memReadValue;
    logic memReadEnable, memWriteEnable, memReadDone, memWriteDone, grantId, busy;
    logic [DW-1:0] memWriteValue, memReadValue;
    logic [CW-1:0] perfIAccess, perfDAccess, perfConflict;

    tlb_walk_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .i_memAddr(i_memAddr), .i_memReadEnable(i_memReadEnable),
        .i_memWriteEnable(i_memWriteEnable), .i_memWriteValue(i_memWriteValue),
        .i_lock(i_lock), .i_memReadDone(i_memReadDone), .i_memWriteDone(i_memWriteDone),
        .i_memReadValue(i_memReadValue),
        .d_memAddr(d_memAddr), .d_memReadEnable(d_memReadEnable),
        .d_memWriteEnable(d_memWriteEnable), .d_memWriteValue(d_memWriteValue),
        .d_lock(d_lock), .d_memReadDone(d_memReadDone), .d_memWriteDone(d_memWriteDone),
        .d_memReadValue(d_memReadValue),
        .memAddr(memAddr), .memReadEnable(memReadEnable), .memWriteEnable(memWriteEnable),
        .memWriteValue(memWriteValue), .memReadDone(memReadDone),
        .memWriteDone(memWriteDone), .memReadValue(memReadValue),
        .grantId(grantId), .busy(busy),
        .perfIAccess(perfIAccess), .perfDAccess(perfDAccess), .perfConflict(perfConflict)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the port, and the access it is running.
    int            m_owner;   // -1 nobody, 0 ITLB, 1 DTLB
    bit            m_active;
    logic [AW-1:0] m_addr;
    bit            m_rd, m_wr;
    logic [DW-1:0] m_wdata;
    int            m_last;
    logic [CW-1:0] m_ci, m_cd, m_cc;

    // Memory responder state
    int            mem_wait;
    int            force_lat;
    bit            force_rval_en;
    logic [DW-1:0] force_rval;

    // Per-cycle expectations
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic e_rd, e_wr, e_busy, e_gid, e_done, e_ird, e_iwr, e_drd, e_dwr;
    logic [CW-1:0] e_pi, e_pd, e_pc;
    int started_owner;

    function automatic void model_reset();
        m_owner = -1; m_active = 0; m_addr = '0; m_rd = 0; m_wr = 0; m_wdata = '0;
        m_last = 1; m_ci = '0; m_cd = '0; m_cc = '0; mem_wait = -1;
    endfunction

    function automatic void take(int w);
        m_owner  = w;
        m_active = 1;
        m_addr   = (w == 0) ? i_memAddr : d_memAddr;
        m_wdata  = (w == 0) ? i_memWriteValue : d_memWriteValue;
        m_rd     = (w == 0) ? i_memReadEnable : d_memReadEnable;
        m_wr     = ((w == 0) ? i_memWriteEnable : d_memWriteEnable) && !m_rd;
        started_owner = w;
    endfunction

    // Memory responder plus expected outputs for the current cycle.
    task automatic drive_mem();
        memReadDone  = 1'b0;
        memWriteDone = 1'b0;
        memReadValue = force_rval_en ? force_rval : $urandom;
        if (m_active) begin
            if (mem_wait < 0) mem_wait = (force_lat >= 0) ? force_lat : $urandom_range(0, 3);
            if (mem_wait == 0) begin
                if (m_rd) memReadDone = 1'b1; else memWriteDone = 1'b1;
                mem_wait = -1;
            end else begin
                mem_wait--;
                // Mismatched done kind must be ignored.
                if ($urandom_range(0, 3) == 0) begin
                    if (m_rd) memWriteDone = 1'b1; else memReadDone = 1'b1;
                end
            end
        end else if ($urandom_range(0, 7) == 0) begin
            memReadDone = 1'b1;
        end
        #1;
        e_addr  = m_active ? m_addr : '0;
        e_wdata = m_active ? m_wdata : '0;
        e_rd    = m_active && m_rd;
        e_wr    = m_active && m_wr;
        e_busy  = (m_owner >= 0);
        e_gid   = (m_owner == 1);
        e_done  = m_active && ((memReadDone && m_rd) || (memWriteDone && m_wr));
        e_ird   = e_done && m_owner == 0 && m_rd;
        e_iwr   = e_done && m_owner == 0 && m_wr;
        e_drd   = e_done && m_owner == 1 && m_rd;
        e_dwr   = e_done && m_owner == 1 && m_wr;
        e_pi    = PerfEn ? m_ci : '0;
        e_pd    = PerfEn ? m_cd : '0;
        e_pc    = PerfEn ? m_cc : '0;
    endtask

    task automatic advance();
        bit ireq, dreq, olock;
        ireq = i_memReadEnable || i_memWriteEnable;
        dreq = d_memReadEnable || d_memWriteEnable;
        started_owner = -1;
        if (rst) begin
            model_reset();
        end else begin
            olock = (m_owner == 0) ? i_lock : d_lock;
            if ((m_owner == 0 && dreq) || (m_owner == 1 && ireq)) m_cc++;
            if (m_active) begin
                if (e_done) begin
                    if (m_owner == 0) m_ci++; else m_cd++;
                    m_last = m_owner; m_active = 0; m_addr = '0; m_wdata = '0;
                    m_rd = 0; m_wr = 0;
                    if (!olock) m_owner = -1;
                end
            end else if (m_owner >= 0) begin
                if ((m_owner == 0) ? ireq : dreq) take(m_owner);
                else if (!olock) m_owner = -1;
            end else if (ireq && dreq) begin
                take((m_last == 0) ? 1 : 0);
            end else if (ireq) begin
                take(0);
            end else if (dreq) begin
                take(1);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        i_memReadEnable = 0; i_memWriteEnable = 0; i_lock = 0;
        d_memReadEnable = 0; d_memWriteEnable = 0; d_lock = 0;
    endtask

    task automatic go_idle();
        clear_reqs();
        for (int k = 0; k < 20 && (m_owner >= 0); k++) begin
            drive_mem();
            advance();
        end
    endtask

    task automatic pulse_reset();
        clear_reqs();
        rst = 1; drive_mem(); advance();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        drive_mem();
        checks++;
        if (memReadEnable !== 0 || memWriteEnable !== 0 || busy !== 0 || grantId !== 0 ||
            memAddr !== '0 || memWriteValue !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b wr=%b busy=%b gid=%b addr=%h wd=%h, want zeros",
                     memReadEnable, memWriteEnable, busy, grantId, memAddr, memWriteValue);
        end
        checks++;
        if (perfIAccess !== '0 || perfDAccess !== '0 || perfConflict !== '0) begin
            errors++;
            $display("FAIL reset_counters: got %h %h %h, want 0", perfIAccess, perfDAccess,
                     perfConflict);
        end
        checks++;
        if (i_memReadDone || i_memWriteDone || d_memReadDone || d_memWriteDone) begin
            errors++;
            $display("FAIL reset_dones: got %b%b%b%b want 0000", i_memReadDone,
                     i_memWriteDone, d_memReadDone, d_memWriteDone);
        end
        advance();
        rst = 0;
    endtask

    task automatic test_itlb_read_alone();
        force_lat = 2; force_rval_en = 1; force_rval = 32'h2000_00CF;
        i_memAddr = 34'h0_8000_1000; i_memReadEnable = 1;
        for (int c = 0; c < 6; c++) begin
            if (c >= 4) i_memReadEnable = 0;
            drive_mem();
            checks++;
            if (memReadEnable !== (c >= 1 && c <= 3) || busy !== (c >= 1 && c <= 3)) begin
                errors++;
                $display("FAIL ird_enable c=%0d: got en=%b busy=%b want %b", c, memReadEnable,
                         busy, (c >= 1 && c <= 3));
            end
            checks++;
            if (i_memReadDone !== (c == 3) || d_memReadDone !== 0) begin
                errors++;
                $display("FAIL ird_done c=%0d: got i=%b d=%b want i=%b d=0", c, i_memReadDone,
                         d_memReadDone, (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (i_memReadValue !== 32'h2000_00CF || memAddr !== 34'h0_8000_1000) begin
                    errors++;
                    $display("FAIL ird_value: got %h @%h want 200000cf @080001000",
                             i_memReadValue, memAddr);
                end
            end
            advance();
        end
        force_lat = -1; force_rval_en = 0;
    endtask

    task automatic test_alternation();
        int n;
        bit pending;
        pulse_reset();
        i_memAddr = 34'h1000; d_memAddr = 34'h2000;
        i_memReadEnable = 1; d_memReadEnable = 1;
        n = 0; pending = 0;
        for (int k = 0; k < 60 && n < 4; k++) begin
            drive_mem();
            if (pending) begin
                checks++;
                if (grantId !== n[0] || busy !== 1) begin
                    errors++;
                    $display("FAIL alternate_%0d: got gid=%b busy=%b want gid=%b busy=1", n,
                             grantId, busy, n[0]);
                end
                n++;
                pending = 0;
            end
            advance();
            if (started_owner >= 0) pending = 1;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL alternate_count: got %0d grants want 4", n);
        end
        go_idle();
    endtask

    task automatic test_locked_walk();
        int stage, waited, hold_cycles;
        logic [CW-1:0] c0;
        go_idle();
        c0 = perfConflict;
        d_memAddr = 34'h0_9000_0040; d_lock = 1; d_memReadEnable = 1;
        i_memAddr = 34'h0_1234_5000;
        stage = 0; waited = 0; hold_cycles = 0;
        for (int k = 0; k < 60 && stage < 4; k++) begin
            if (k == 1) i_memReadEnable = 1;
            drive_mem();
            if (stage < 3) begin
                checks++;
                if (k > 0 && (grantId !== 1 || busy !== 1)) begin
                    errors++;
                    $display("FAIL lock_owner k=%0d: got gid=%b busy=%b want 1 1", k, grantId,
                             busy);
                end
            end
            if (stage == 1 && memWriteEnable) begin
                checks++;
                if (memWriteValue !== 32'h2000_00DF || memAddr !== 34'h0_9000_0040) begin
                    errors++;
                    $display("FAIL lock_write: got %h @%h want 200000df @090000040",
                             memWriteValue, memAddr);
                end
            end
            if (i_memReadEnable && e_busy) waited++;
            if (stage == 0 && d_memReadDone) begin
                stage = 1;
                advance();
                d_memReadEnable = 0; d_memWriteEnable = 1; d_memWriteValue = 32'h2000_00DF;
                continue;
            end
            if (stage == 1 && d_memWriteDone) begin
                stage = 2;
                advance();
                d_memWriteEnable = 0;
                continue;
            end
            if (stage == 2) begin
                hold_cycles++;
                if (hold_cycles == 3) begin d_lock = 0; stage = 3; end
            end else if (stage == 3) begin
                checks++;
                if (busy !== 0) begin
                    errors++;
                    $display("FAIL lock_release: got busy=%b want 0", busy);
                end
                stage = 4;
            end
            advance();
        end
        drive_mem();
        checks++;
        if (grantId !== 0 || busy !== 1 || memAddr !== 34'h0_1234_5000) begin
            errors++;
            $display("FAIL lock_itlb_after: got gid=%b busy=%b addr=%h want 0 1 012345000",
                     grantId, busy, memAddr);
        end
        checks++;
        if (perfConflict - c0 !== (PerfEn ? CW'(waited) : '0)) begin
            errors++;
            $display("FAIL lock_conflicts: got %0d want %0d", perfConflict - c0,
                     PerfEn ? waited : 0);
        end
        advance();
        go_idle();
    endtask

    task automatic test_abort();
        go_idle();
        force_lat = 3;
        i_memAddr = 34'h2_0000_0abc; i_memReadEnable = 1;
        drive_mem(); advance();
        i_memReadEnable = 0; i_memAddr = 34'h3_ffff_f000;
        for (int c = 1; c <= 5; c++) begin
            drive_mem();
            if (c <= 4) begin
                checks++;
                if (memReadEnable !== 1 || memAddr !== 34'h2_0000_0abc) begin
                    errors++;
                    $display("FAIL abort_hold c=%0d: got en=%b addr=%h want 1 200000abc", c,
                             memReadEnable, memAddr);
                end
            end
            if (c == 4) begin
                checks++;
                if (i_memReadDone !== 1) begin
                    errors++;
                    $display("FAIL abort_done: got %b want 1", i_memReadDone);
                end
            end
            if (c == 5) begin
                checks++;
                if (busy !== 0 || memReadEnable !== 0) begin
                    errors++;
                    $display("FAIL abort_idle: got busy=%b en=%b want 0 0", busy, memReadEnable);
                end
            end
            advance();
        end
        force_lat = -1;
    endtask

    task automatic test_reset_mid();
        go_idle();
        force_lat = 6;
        i_memAddr = 34'h0_0000_4000; i_memReadEnable = 1;
        drive_mem(); advance();
        i_memReadEnable = 0;
        drive_mem(); advance();
        rst = 1;
        drive_mem(); advance();
        rst = 0;
        drive_mem();
        checks++;
        if (memReadEnable !== 0 || busy !== 0 || memAddr !== '0) begin
            errors++;
            $display("FAIL midreset_idle: got en=%b busy=%b addr=%h want 0 0 0", memReadEnable,
                     busy, memAddr);
        end
        checks++;
        if (perfIAccess !== '0 || perfDAccess !== '0 || perfConflict !== '0) begin
            errors++;
            $display("FAIL midreset_counters: got %h %h %h want 0", perfIAccess, perfDAccess,
                     perfConflict);
        end
        force_lat = -1;
        i_memReadEnable = 1; d_memReadEnable = 1;
        advance();
        drive_mem();
        checks++;
        if (grantId !== 0 || busy !== 1) begin
            errors++;
            $display("FAIL midreset_first_grant: got gid=%b busy=%b want 0 1", grantId, busy);
        end
        advance();
        go_idle();
    endtask

    task automatic test_rw_both();
        bit seen;
        go_idle();
        force_lat = 1;
        d_memAddr = 34'h0_5555_0000; d_memWriteValue = 32'hdead_beef;
        d_memReadEnable = 1; d_memWriteEnable = 1;
        drive_mem(); advance();
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            drive_mem();
            if (c < 2) begin
                checks++;
                if (memReadEnable !== 1 || memWriteEnable !== 0) begin
                    errors++;
                    $display("FAIL rwboth_en c=%0d: got rd=%b wr=%b want 1 0", c,
                             memReadEnable, memWriteEnable);
                end
            end
            if (d_memReadDone) seen = 1;
            checks++;
            if (d_memWriteDone !== 0) begin
                errors++;
                $display("FAIL rwboth_wrdone c=%0d: got %b want 0", c, d_memWriteDone);
            end
            advance();
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL rwboth_rddone: got none want d_memReadDone pulse");
        end
        force_lat = -1;
        go_idle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 3) == 0 || i_memReadDone || i_memWriteDone) begin
                i_memReadEnable = ($urandom_range(0, 2) == 0);
                i_memWriteEnable = ($urandom_range(0, 3) == 0);
                i_memAddr = {$urandom, $urandom}; i_memWriteValue = $urandom;
            end
            if ($urandom_range(0, 3) == 0 || d_memReadDone || d_memWriteDone) begin
                d_memReadEnable = ($urandom_range(0, 2) == 0);
                d_memWriteEnable = ($urandom_range(0, 3) == 0);
                d_memAddr = {$urandom, $urandom}; d_memWriteValue = $urandom;
            end
            if ($urandom_range(0, 7) == 0) i_lock = ~i_lock;
            if ($urandom_range(0, 7) == 0) d_lock = ~d_lock;
            drive_mem();
            checks++;
            if (memAddr !== e_addr || memReadEnable !== e_rd || memWriteEnable !== e_wr ||
                memWriteValue !== e_wdata) begin
                errors++;
                $display("FAIL rnd_port k=%0d: got %h %b %b %h want %h %b %b %h", k, memAddr,
                         memReadEnable, memWriteEnable, memWriteValue, e_addr, e_rd, e_wr,
                         e_wdata);
            end
            checks++;
            if (busy !== e_busy || (e_busy && grantId !== e_gid)) begin
                errors++;
                $display("FAIL rnd_grant k=%0d: got busy=%b gid=%b want %b %b", k, busy,
                         grantId, e_busy, e_gid);
            end
            checks++;
            if (i_memReadDone !== e_ird || i_memWriteDone !== e_iwr ||
                d_memReadDone !== e_drd || d_memWriteDone !== e_dwr) begin
                errors++;
                $display("FAIL rnd_done k=%0d: got %b%b%b%b want %b%b%b%b", k, i_memReadDone,
                         i_memWriteDone, d_memReadDone, d_memWriteDone, e_ird, e_iwr, e_drd,
                         e_dwr);
            end
            checks++;
            if (i_memReadValue !== memReadValue || d_memReadValue !== memReadValue) begin
                errors++;
                $display("FAIL rnd_rvalue k=%0d: got %h %h want %h", k, i_memReadValue,
                         d_memReadValue, memReadValue);
            end
            checks++;
            if (perfIAccess !== e_pi || perfDAccess !== e_pd || perfConflict !== e_pc) begin
                errors++;
                $display("FAIL rnd_perf k=%0d: got %0d %0d %0d want %0d %0d %0d", k,
                         perfIAccess, perfDAccess, perfConflict, e_pi, e_pd, e_pc);
            end
            advance();
        end
        rst = 0;
    endtask

    initial begin
        rst = 1;
        clear_reqs();
        i_memAddr = '0; d_memAddr = '0; i_memWriteValue = '0; d_memWriteValue = '0;
        memReadDone = 0; memWriteDone = 0; memReadValue = '0;
        force_lat = -1; force_rval_en = 0; force_rval = '0;
        model_reset();
        @(posedge clk);
        #1;
        test_reset();
        test_itlb_read_alone();
        test_alternation();
        test_locked_walk();
        test_abort();
        test_reset_mid();
        test_rw_both();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
